// File: rtl/qupls_regfile_tmux_pkg.sv
// Shared types for the time-multiplexed register file: value/register-number
// types, storage depth and the initialisation state encoding.
package qupls_regfile_tmux_pkg;

  localparam int PREGS = 512;

  typedef logic [63:0]                value_t;
  typedef logic [$clog2(PREGS)-1:0]   pregno_t;

  localparam value_t value_zero = '0;

  typedef enum logic [1:0] {
    CLEAR,
    WAIT_PH,
    RUN
  } init_state_t;

endpackage

// File: rtl/qupls_regfile_ram.sv
// One read replica of the register file: simple dual-port storage with a
// single write port and a registered read port, both on clk5x.
module qupls_regfile_ram
  import qupls_regfile_tmux_pkg::*;
#(
  parameter  int WID = $bits(value_t),
  parameter  int DEP = PREGS,
  localparam int AW  = $clog2(DEP)
) (
  input  logic           clk5x,
  input  logic           we,
  input  logic [AW-1:0]  wa,
  input  logic [WID-1:0] wd,
  input  logic [AW-1:0]  ra,
  output logic [WID-1:0] rd
);

  logic [WID-1:0] mem [DEP];

  // NOTE: the array has no reset; it is zeroed by the CLEAR sweep through the
  // write port, which keeps it mappable onto block RAM.
  always_ff @(posedge clk5x) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end

endmodule

// File: rtl/qupls_regfile_tmux.sv
// Time-multiplexed register file: NW write ports are serialised onto one storage
// write per clk5x phase, read through NR replicas with same-cycle bypass.
module qupls_regfile_tmux
  import qupls_regfile_tmux_pkg::*;
#(
  parameter  int WID = $bits(value_t),
  parameter  int DEP = PREGS,
  parameter  int NW  = 4,
  parameter  int NR  = 16,
  parameter  int NPH = 5,
  localparam int AW  = $clog2(DEP),
  localparam int PCW = $clog2(NPH)
) (
  input  logic                   rst,
  input  logic                   clk5x,
  input  logic                   ph0,
  input  logic [NW-1:0]          we,
  input  logic [NW-1:0][AW-1:0]  wa,
  input  logic [NW-1:0][WID-1:0] wd,
  input  logic [NR-1:0][AW-1:0]  ra,
  output logic [NR-1:0][WID-1:0] rd,
  output logic                   rdy,
  output logic                   err_phase
);

  localparam logic [PCW-1:0] PC_LAST = PCW'(NPH - 1);

  init_state_t state, state_nx;
  logic [AW-1:0]          clr_addr;
  logic [PCW-1:0]         pc;
  logic [NW-1:0]          keep;
  logic [NW-1:0]          hold_we;
  logic [NW-1:0][AW-1:0]  hold_wa;
  logic [NW-1:0][WID-1:0] hold_wd;
  logic [NR-1:0][AW-1:0]  ra_q;
  logic                   ram_we;
  logic [AW-1:0]          ram_wa;
  logic [WID-1:0]         ram_wd;
  logic [WID-1:0]         ram_dout [NR];
  logic [NR-1:0][WID-1:0] rd_nx;

  always_ff @(posedge clk5x) begin
    if (rst) state <= CLEAR;
    else     state <= state_nx;
  end

  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (clr_addr == AW'(DEP - 1)) state_nx = WAIT_PH;
      WAIT_PH: if (ph0) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  assign rdy = (state == RUN);

  always_ff @(posedge clk5x) begin
    if (rst)                 clr_addr <= '0;
    else if (state == CLEAR) clr_addr <= clr_addr + AW'(1);
  end

  always_ff @(posedge clk5x) begin
    if (rst || ph0)          pc <= '0;
    else if (pc != PC_LAST)  pc <= pc + PCW'(1);
  end

  // Once synchronised in RUN, ph0 must coincide exactly with pc reaching its last value.
  always_ff @(posedge clk5x) begin
    if (rst) err_phase <= 1'b0;
    else if (state == RUN && (ph0 != (pc == PC_LAST))) err_phase <= 1'b1;
  end

  // A port survives only if it writes a non-zero register no higher port also targets.
  always_comb begin
    keep = '0;
    for (int k = 0; k < NW; k++) begin
      keep[k] = we[k] && (wa[k] != '0);
      for (int j = k + 1; j < NW; j++)
        if (we[j] && wa[j] == wa[k]) keep[k] = 1'b0;
    end
  end

  always_ff @(posedge clk5x) begin
    if (rst)      hold_we <= '0;
    else if (ph0) hold_we <= (state == RUN) ? keep : '0;
  end

  // NOTE: address/data holding registers carry no reset; hold_we alone qualifies them.
  always_ff @(posedge clk5x) begin
    if (ph0) begin
      hold_wa <= wa;
      hold_wd <= wd;
      ra_q    <= ra;
    end
  end

  always_comb begin
    ram_we = 1'b0;
    ram_wa = '0;
    ram_wd = '0;
    if (state == CLEAR) begin
      ram_we = 1'b1;
      ram_wa = clr_addr;
    end else if (state == RUN) begin
      for (int k = 0; k < NW; k++) begin
        if (pc == PCW'(k)) begin
          ram_we = hold_we[k];
          ram_wa = hold_wa[k];
          ram_wd = hold_wd[k];
        end
      end
    end
    if (rst) ram_we = 1'b0;
  end

  for (genvar r = 0; r < NR; r++) begin : g_rep
    qupls_regfile_ram #(.WID(WID), .DEP(DEP)) u_ram (
      .clk5x (clk5x),
      .we    (ram_we),
      .wa    (ram_wa),
      .wd    (ram_wd),
      .ra    (ra_q[r]),
      .rd    (ram_dout[r])
    );
  end

  // The last port's commit lands too late for the replica read, so held data wins.
  always_comb begin
    rd_nx = '0;
    for (int r = 0; r < NR; r++) begin
      rd_nx[r] = ram_dout[r];
      for (int k = 0; k < NW; k++)
        if (hold_we[k] && hold_wa[k] == ra_q[r]) rd_nx[r] = hold_wd[k];
      if (ra_q[r] == '0) rd_nx[r] = WID'(value_zero);
    end
  end

  always_ff @(posedge clk5x) begin
    if (rst || state != RUN) rd <= '0;
    else if (ph0)            rd <= rd_nx;
  end

endmodule

// File: tb/tb_qupls_regfile_tmux.sv
// Scoreboard bench for qupls_regfile_tmux: a CPU-cycle-level register-file model
// predicts every read port; a monitor compares each time rd is refreshed.
module tb_qupls_regfile_tmux;

  localparam int WID = 64;
  localparam int DEP = 512;
  localparam int NW  = 4;
  localparam int NR  = 16;
  localparam int NPH = 5;
  localparam int AW  = 9;

  typedef logic [NR-1:0][WID-1:0] rdvec_t;
  typedef logic [NW-1:0][AW-1:0]  wavec_t;
  typedef logic [NW-1:0][WID-1:0] wdvec_t;
  typedef logic [NR-1:0][AW-1:0]  ravec_t;

  logic          rst;
  logic          clk5x;
  logic          ph0;
  logic [NW-1:0] we;
  wavec_t        wa;
  wdvec_t        wd;
  ravec_t        ra;
  rdvec_t        rd;
  logic          rdy;
  logic          err_phase;

  qupls_regfile_tmux #(.WID(WID), .DEP(DEP), .NW(NW), .NR(NR), .NPH(NPH)) dut (
    .rst       (rst),
    .clk5x     (clk5x),
    .ph0       (ph0),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .ra        (ra),
    .rd        (rd),
    .rdy       (rdy),
    .err_phase (err_phase)
  );

  logic [WID-1:0] mem [DEP];
  rdvec_t         exp_q [$];
  int             n_vec = 0;
  int             n_err = 0;
  int             ph_space = NPH;
  int             n_out = 0;

  initial clk5x = 1'b0;
  always #5 clk5x = ~clk5x;

  // ph0 is driven just after the edge, high for one fast cycle every ph_space cycles.
  initial begin : ph_gen
    int cnt;
    cnt = 0;
    ph0 = 1'b0;
    forever begin
      @(posedge clk5x);
      #1;
      if (cnt >= ph_space - 1) begin
        ph0 = 1'b1;
        cnt = 0;
      end else begin
        ph0 = 1'b0;
        cnt++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [WID-1:0] got, input logic [WID-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(3, 0) == 0) return AW'($urandom_range(DEP - 1, 0));
    return AW'($urandom_range(15, 0));
  endfunction

  // Storage is empty after init; the capture made on the ph0 that enters RUN reads zeros.
  task automatic model_clear();
    for (int i = 0; i < DEP; i++) mem[i] = '0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  // Present one CPU cycle's inputs for the next RUN ph0 and queue the predicted reads.
  task automatic cpu_cycle(input logic [NW-1:0] en, input wavec_t a, input wdvec_t d, input ravec_t r_a);
    rdvec_t e;
    int     guard;
    guard = 0;
    do begin
      @(negedge clk5x);
      guard++;
    end while (!(ph0 && rdy) && guard < 40);
    if (!(ph0 && rdy)) begin
      n_vec++;
      n_err++;
      $display("FAIL cpu_cycle: no ph0 with rdy within 40 cycles");
    end
    we = en;
    wa = a;
    wd = d;
    ra = r_a;
    for (int p = 0; p < NW; p++)
      if (en[p] && a[p] != '0) mem[a[p]] = d[p];
    for (int r = 0; r < NR; r++)
      e[r] = (r_a[r] == '0) ? '0 : mem[r_a[r]];
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    ravec_t r_a;
    for (int i = 0; i < n; i++) begin
      for (int r = 0; r < NR; r++) r_a[r] = pick_addr();
      cpu_cycle('0, '0, '0, r_a);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk5x);
    #1;
    rst = 1'b1;
    we  = '0;
    model_clear();
    repeat (3) @(negedge clk5x);
    check_bit("reset rdy", rdy, 1'b0);
    check_bit("reset err_phase", err_phase, 1'b0);
    check_bit("reset rd nonzero", |rd, 1'b0);
    #1 rst = 1'b0;
  endtask

  // rdy must rise on the first ph0 after the DEP-cycle clear sweep.
  task automatic wait_ready(input string tag);
    int   cnt;
    logic ph_prev;
    cnt = 0;
    ph_prev = 1'b0;
    while (!rdy && cnt < 2000) begin
      ph_prev = ph0;
      @(negedge clk5x);
      cnt++;
    end
    check_bit({tag, " rdy rose"}, rdy, 1'b1);
    check_bit({tag, " rdy cycle window"}, (cnt > DEP && cnt <= DEP + NPH), 1'b1);
    check_bit({tag, " rdy on ph0"}, ph_prev, 1'b1);
    if (cnt <= DEP || cnt > DEP + NPH) $display("  %s: rdy after %0d cycles", tag, cnt);
  endtask

  initial begin : monitor
    logic   pend;
    rdvec_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk5x);
      if (pend) begin
        pend = 1'b0;
        n_out++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard underflow at output %0d", n_out);
        end else begin
          e = exp_q.pop_front();
          for (int r = 0; r < NR; r++)
            check($sformatf("rd[%0d] output %0d", r, n_out), rd[r], e[r]);
        end
      end
      if (ph0 && rdy) pend = 1'b1;
    end
  end

  initial begin : main
    logic [NW-1:0] en;
    wavec_t        a;
    wdvec_t        d;
    ravec_t        r_a;

    rst = 1'b1;
    we  = '0;
    wa  = '0;
    wd  = '0;
    ra  = '0;
    reset_dut();
    wait_ready("init");
    idle(3);

    // Four ports write r5..r8; r7 and r8 are also read in the same CPU cycle.
    en = '1;
    for (int p = 0; p < NW; p++) begin
      a[p] = AW'(5 + p);
      d[p] = WID'(10 + p);
    end
    for (int r = 0; r < NR; r++) r_a[r] = AW'(r % 10);
    r_a[0] = AW'(7);
    r_a[1] = AW'(8);
    cpu_cycle(en, a, d, r_a);
    for (int r = 0; r < NR; r++) r_a[r] = AW'(5 + (r % 4));
    cpu_cycle('0, '0, '0, r_a);

    // Ports 1 and 3 collide on r9; port 3 must win.
    en = 4'b1010;
    a  = '0;
    d  = '0;
    a[1] = AW'(9);
    d[1] = 64'h11;
    a[3] = AW'(9);
    d[3] = 64'h33;
    for (int r = 0; r < NR; r++) r_a[r] = AW'(9);
    cpu_cycle(en, a, d, r_a);
    cpu_cycle('0, '0, '0, r_a);

    // Writes to r0 are suppressed, also on the bypass path.
    en = 4'b0001;
    a  = '0;
    d  = '0;
    d[0] = 64'hFFFF;
    r_a  = '0;
    cpu_cycle(en, a, d, r_a);
    cpu_cycle('0, '0, '0, r_a);

    for (int n = 0; n < 150; n++) begin
      for (int p = 0; p < NW; p++) begin
        en[p] = 1'($urandom_range(1, 0));
        a[p]  = pick_addr();
        d[p]  = {$urandom, $urandom};
      end
      for (int r = 0; r < NR; r++) r_a[r] = pick_addr();
      cpu_cycle(en, a, d, r_a);
    end

    // ph0 spacing of 4, then 6; err_phase latches on the first anomaly.
    idle(2);
    check_bit("err_phase before anomaly", err_phase, 1'b0);
    ph_space = 4;
    idle(1);
    ph_space = 6;
    @(negedge clk5x);
    check_bit("err_phase after short spacing", err_phase, 1'b1);
    idle(1);
    ph_space = NPH;
    idle(3);
    check_bit("err_phase sticky", err_phase, 1'b1);

    // Held write to r12 is aborted by reset before it commits.
    en = 4'b1000;
    a  = '0;
    d  = '0;
    a[3] = AW'(12);
    d[3] = 64'hDEAD_BEEF;
    for (int r = 0; r < NR; r++) r_a[r] = AW'(12);
    cpu_cycle(en, a, d, r_a);
    reset_dut();
    wait_ready("reinit");
    cpu_cycle('0, '0, '0, r_a);
    cpu_cycle('0, '0, '0, r_a);
    idle(2);
    check_bit("err_phase after reinit", err_phase, 1'b0);

    repeat (3) @(negedge clk5x);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
